// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads instruction memory at the PC with req/ack, buffers words in a DEPTH-entry FIFO for the decoder.
// Latency: a word acked at edge N is presented on ir_o with ir_valid_o=1 after edge N when the FIFO was empty.
// Backpressure: the FIFO holds words while ir_ready_i=0; no new fetch starts while the FIFO is full.
module instr_fetch_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              re_n_i,
    input  logic [ADDR_W-1:0] pc_in_i,
    output logic              pc_inc_o,
    output logic              pc_w_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] ir_o,
    output logic              ir_valid_o,
    input  logic              ir_ready_i,
    output logic              fetch_fault_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(MAX_WAIT + 1);

    // DRAIN waits out a request that a flush has already made useless;
    // the memory handshake may not be withdrawn, so the request stays up.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic push;
    logic pop;
    logic pc_pulse;
    logic fifo_full;
    logic timed_out;

    assign fifo_full = (count_q == CNT_W'(DEPTH));
    // The cycle that would bring the no-ack count to MAX_WAIT is the last REQ/DRAIN cycle.
    assign timed_out = (timer_q >= TMR_W'(MAX_WAIT - 1));

    // FSM state, fetch address and timeout timer registers
    always_ff @(posedge clk_i) begin
        if (!re_n_i) begin
            state_q <= IDLE;
            faddr_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            faddr_q <= faddr_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic, FIFO push and the PC increment/write pulse
    always_comb begin
        state_d  = state_q;
        faddr_d  = faddr_q;
        timer_d  = timer_q;
        push     = 1'b0;
        pc_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                // PC is sampled only here, so a branch load at a flush edge is picked up next time
                if (!flush_i && !fifo_full) begin
                    state_d = REQ;
                    faddr_d = pc_in_i;
                    timer_d = '0;
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (!flush_i) begin
                        push     = 1'b1;
                        pc_pulse = 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = FAULT;
                    timer_d = TMR_W'(MAX_WAIT);
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (flush_i) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timed_out) begin
                    state_d = FAULT;
                    timer_d = TMR_W'(MAX_WAIT);
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            FAULT: begin
                if (flush_i) begin
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset wins even over an ack arriving in the same cycle
        if (!re_n_i) begin
            push     = 1'b0;
            pc_pulse = 1'b0;
        end
    end

    assign pop = ir_valid_o && ir_ready_i;

    // Instruction FIFO: a flush empties it and outranks both push and pop
    always_ff @(posedge clk_i) begin
        if (!re_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= mem_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign mem_req_o     = (state_q == REQ) || (state_q == DRAIN);
    assign mem_addr_o    = faddr_q;
    assign fetch_fault_o = (state_q == FAULT);
    assign pc_inc_o      = pc_pulse;
    assign pc_w_o        = pc_pulse;
    assign ir_o          = mem_q[rd_ptr_q];
    assign ir_valid_o    = (count_q != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand sequences and randomized traffic vs a reference model.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
// The reference model treats the fetch as "one outstanding request" plus a queue of words.
module tb_instr_fetch_unit;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        re_n = 1'b0;
    logic [15:0] pc_in = '0;
    logic        pc_inc, pc_w, mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = '0;
    logic        flush = 1'b0;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        fetch_fault;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    bit          m_busy, m_discard, m_fault;
    int          m_wait;
    logic [15:0] m_addr;
    logic [15:0] m_q[$];

    instr_fetch_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk), .re_n_i(re_n), .pc_in_i(pc_in), .pc_inc_o(pc_inc), .pc_w_o(pc_w),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
        .flush_i(flush), .ir_o(ir), .ir_valid_o(ir_valid), .ir_ready_i(ir_ready),
        .fetch_fault_o(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic re; logic [15:0] pc; logic ack; logic [15:0] dat; logic fl; logic rdy;
        logic chk; logic req; logic [15:0] addr; logic inc; logic ival; logic [15:0] ir; logic flt;
    } vec_t;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_update();
        bit do_pop, do_push;
        do_pop  = (m_q.size() != 0) && ir_ready;
        do_push = 1'b0;
        if (!re_n) begin
            m_busy = 0; m_discard = 0; m_fault = 0; m_wait = 0; m_addr = '0;
            m_q.delete();
            return;
        end
        if (m_busy) begin
            if (mem_ack) begin
                do_push = !m_discard && !flush;
                m_busy  = 0;
                m_wait  = 0;
            end else if (m_wait == MAX_WAIT - 1) begin
                m_busy  = 0;
                m_fault = 1;
            end else begin
                m_wait++;
                if (flush) m_discard = 1;
            end
        end else if (m_fault) begin
            if (flush) begin
                m_fault = 0;
                m_wait  = 0;
            end
        end else if (!flush && m_q.size() < DEPTH) begin
            m_busy    = 1;
            m_discard = 0;
            m_wait    = 0;
            m_addr    = pc_in;
        end
        if (flush) begin
            m_q.delete();
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(mem_data);
        end
    endtask

    task automatic model_check();
        logic e_inc;
        e_inc = re_n && m_busy && !m_discard && mem_ack && !flush;
        chk1("mdl_mem_req", mem_req, m_busy);
        chk16("mdl_mem_addr", mem_addr, m_addr);
        chk1("mdl_pc_inc", pc_inc, e_inc);
        chk1("mdl_pc_w", pc_w, e_inc);
        chk1("mdl_fault", fetch_fault, m_fault);
        chk1("mdl_ir_valid", ir_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk16("mdl_ir", ir, m_q[0]);
    endtask

    // One cycle: model the edge just taken, drive new inputs, then compare against the model.
    task automatic step(input logic re, input logic [15:0] pc, input logic ack,
                        input logic [15:0] dat, input logic fl, input logic rdy);
        @(posedge clk);
        model_update();
        @(negedge clk);
        re_n = re; pc_in = pc; mem_ack = ack; mem_data = dat; flush = fl; ir_ready = rdy;
        #1;
        model_check();
    endtask

    vec_t tbl[17];
    vec_t v;
    int   ack_pct;

    initial begin
        // re, pc, ack, dat, fl, rdy | chk, req, addr, inc, ival, ir, flt
        tbl[0]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 16'h0099, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[4]  = '{1'b1, 16'h0099, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 16'h0099, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[6]  = '{1'b1, 16'h0011, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b1, 16'hA5C3, 1'b0};
        tbl[7]  = '{1'b1, 16'h0077, 1'b1, 16'hB00B, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0011, 1'b1, 1'b1, 16'hA5C3, 1'b0};
        tbl[8]  = '{1'b1, 16'h0077, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b1, 16'hB00B, 1'b0};
        tbl[9]  = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[10] = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{1'b1, 16'h0200, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[12] = '{1'b1, 16'h0200, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[13] = '{1'b1, 16'h0200, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[14] = '{1'b1, 16'h0200, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[15] = '{1'b1, 16'h0555, 1'b1, 16'h3C3C, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[16] = '{1'b1, 16'h0555, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b1, 16'h3C3C, 1'b0};

        // reset, single fetch, push+pop at count 1, flush during a request
        for (int i = 0; i < 17; i++) begin
            v = tbl[i];
            step(v.re, v.pc, v.ack, v.dat, v.fl, v.rdy);
            if (v.chk) begin
                chk1($sformatf("tbl%0d_mem_req", i), mem_req, v.req);
                chk16($sformatf("tbl%0d_mem_addr", i), mem_addr, v.addr);
                chk1($sformatf("tbl%0d_pc_inc", i), pc_inc, v.inc);
                chk1($sformatf("tbl%0d_pc_w", i), pc_w, v.inc);
                chk1($sformatf("tbl%0d_ir_valid", i), ir_valid, v.ival);
                chk1($sformatf("tbl%0d_fault", i), fetch_fault, v.flt);
                if (v.ival || !v.re) chk16($sformatf("tbl%0d_ir", i), ir, v.ir);
            end
        end

        // full FIFO blocks fetching; draining restarts it
        step(1'b1, 16'h0300, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0301, 1'b1, 16'h1111, 1'b0, 1'b0);
        chk1("full_inc1", pc_inc, 1'b1);
        step(1'b1, 16'h0302, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0303, 1'b1, 16'h2222, 1'b0, 1'b0);
        chk1("full_inc2", pc_inc, 1'b1);
        chk16("full_addr2", mem_addr, 16'h0302);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0304, 1'b0, 16'h0000, 1'b0, 1'b0);
            chk1("full_no_req", mem_req, 1'b0);
            chk16("full_head", ir, 16'h1111);
        end
        step(1'b1, 16'h0400, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk16("drain_first", ir, 16'h1111);
        chk1("drain_first_vld", ir_valid, 1'b1);
        step(1'b1, 16'h0400, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk16("drain_second", ir, 16'h2222);
        chk1("drain_second_no_req", mem_req, 1'b0);
        step(1'b1, 16'h0400, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk1("refetch_req", mem_req, 1'b1);
        chk16("refetch_addr", mem_addr, 16'h0400);
        chk1("refetch_empty", ir_valid, 1'b0);

        // memory timeout: 15 request cycles then a sticky fault
        for (int i = 1; i < MAX_WAIT; i++) begin
            step(1'b1, 16'h0400, 1'b0, 16'h0000, 1'b0, 1'b0);
            chk1("wait_req_held", mem_req, 1'b1);
        end
        step(1'b1, 16'h0400, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk1("timeout_req_drop", mem_req, 1'b0);
        chk1("timeout_fault", fetch_fault, 1'b1);
        step(1'b1, 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b0);
        chk1("fault_sticky", fetch_fault, 1'b1);
        chk1("fault_no_req", mem_req, 1'b0);
        step(1'b1, 16'h0400, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk1("fault_until_flush", fetch_fault, 1'b1);
        step(1'b1, 16'h0500, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk1("fault_cleared", fetch_fault, 1'b0);
        chk1("fault_idle", mem_req, 1'b0);
        step(1'b1, 16'h0501, 1'b1, 16'h5A5A, 1'b0, 1'b0);
        chk1("resume_req", mem_req, 1'b1);
        chk16("resume_addr", mem_addr, 16'h0500);
        chk1("resume_inc", pc_inc, 1'b1);
        step(1'b1, 16'h0600, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk16("resume_ir", ir, 16'h5A5A);

        // reset in the middle of a request with an ack present
        step(1'b0, 16'h0600, 1'b1, 16'h7777, 1'b0, 1'b0);
        chk1("rst_req_still_up", mem_req, 1'b1);
        chk1("rst_no_inc", pc_inc, 1'b0);
        step(1'b1, 16'h0600, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk1("rst_req_dropped", mem_req, 1'b0);
        chk1("rst_ir_valid", ir_valid, 1'b0);
        chk1("rst_fault", fetch_fault, 1'b0);

        // randomized traffic; ack probability changes in phases to reach timeouts too
        ack_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0:       ack_pct = 0;
                    1:       ack_pct = 10;
                    2:       ack_pct = 50;
                    default: ack_pct = 90;
                endcase
            end
            step($urandom_range(0, 199) != 0, 16'($urandom), $urandom_range(0, 99) < ack_pct,
                 16'($urandom), $urandom_range(0, 99) < 3, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
